// File: rtl/mips_cpu_hilo_ctrl.sv
// HI/LO sequencer: MULT/MULTU via external multiplier, DIV/DIVU via 32-step restoring divider, MTHI/MTLO.
// Define HILO_DIV_EN to build the divider; without it DIV/DIVU are accepted as no-ops.
module mips_cpu_hilo_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        abort,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_out,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

`ifdef HILO_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1} state_t;
`endif

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic        sgn_q, sgn_d, sa_q, sa_d, sb_q, sb_d;
`ifdef HILO_DIV_EN
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [32:0] rem_sh;
`endif

  logic        op_sgn, accept;
  logic [31:0] rs_abs, rt_abs;
  logic [63:0] prod;

  // Only MULT and DIV (op[0]==0) are signed.
  assign op_sgn = ~op[2] & ~op[0];
  assign rs_abs = (op_sgn & rs_val[31]) ? -rs_val : rs_val;
  assign rt_abs = (op_sgn & rt_val[31]) ? -rt_val : rt_val;
  assign accept = (state_q == S_IDLE) & ~busy_q & op_valid & ~abort;
  assign prod   = (sgn_q & (sa_q ^ sb_q)) ? -mul_out : mul_out;
`ifdef HILO_DIV_EN
  assign rem_sh = {rem_q, quo_q[31]};
`endif

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    sgn_d   = sgn_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
`ifdef HILO_DIV_EN
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
`endif
    if (abort) begin
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          case (op)
            3'd0, 3'd1: begin
              sgn_d   = op_sgn;
              sa_d    = rs_val[31];
              sb_d    = rt_val[31];
              mul_a_d = rs_abs;
              mul_b_d = rt_abs;
              state_d = S_MUL;
              busy_d  = 1'b1;
            end
`ifdef HILO_DIV_EN
            3'd2, 3'd3: begin
              sgn_d   = op_sgn;
              sa_d    = rs_val[31];
              sb_d    = rt_val[31];
              quo_d   = rs_abs;
              dvsr_d  = rt_abs;
              rem_d   = 32'd0;
              cnt_d   = 5'd0;
              state_d = S_DIV;
              busy_d  = 1'b1;
            end
`endif
            3'd4:    hi_d = rs_val;
            3'd5:    lo_d = rs_val;
            default: ;
          endcase
        end
        S_MUL: begin
          {hi_d, lo_d} = prod;
          state_d      = S_IDLE;
          busy_d       = 1'b0;
        end
`ifdef HILO_DIV_EN
        S_DIV: begin
          // Remainder after subtraction is always below the divisor, so 32 bits hold it.
          if (rem_sh >= {1'b0, dvsr_q}) begin
            rem_d = rem_sh[31:0] - dvsr_q;
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = rem_sh[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_FIX;
        end
        S_FIX: begin
          lo_d    = (sgn_q & (sa_q ^ sb_q)) ? -quo_q : quo_q;
          hi_d    = (sgn_q & sa_q) ? -rem_q : rem_q;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
`endif
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      mul_a_q <= 32'd0;
      mul_b_q <= 32'd0;
      sgn_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
`ifdef HILO_DIV_EN
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvsr_q  <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      sgn_q   <= sgn_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
`ifdef HILO_DIV_EN
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;

endmodule

// File: tb/tb_mips_cpu_hilo_ctrl.sv
// Self-checking bench for mips_cpu_hilo_ctrl; reference model uses plain 64-bit arithmetic.
// Divider expectations follow HILO_DIV_EN.
module tb_mips_cpu_hilo_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
  logic        abort = 1'b0;
  logic [31:0] mul_a, mul_b, hi, lo;
  logic [63:0] mul_out = 64'd0;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  mips_cpu_hilo_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .abort(abort),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Shared unsigned multiplier, registered on the falling edge.
  always @(negedge clk) mul_out <= {32'd0, mul_a} * {32'd0, mul_b};

  function automatic int exp_busy(input logic [2:0] o);
    if (o == 3'd0 || o == 3'd1) return 1;
`ifdef HILO_DIV_EN
    if (o == 3'd2 || o == 3'd3) return 33;
`endif
    return 0;
  endfunction

  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      3'd0: begin p = sa * sb; {m_hi, m_lo} = p; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
`ifdef HILO_DIV_EN
      3'd2: if (b == 32'd0) begin
              m_hi = a;
              m_lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
            end else begin
              q = sa / sb; r = sa % sb;
              m_lo = q[31:0]; m_hi = r[31:0];
            end
      3'd3: if (b == 32'd0) begin
              m_hi = a; m_lo = 32'hFFFF_FFFF;
            end else begin
              m_lo = a / b; m_hi = a % b;
            end
`endif
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL busy_timeout busy still %b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    issue(o, a, b);
    wait_idle(n);
    model(o, a, b);
    checks++;
    if (n !== exp_busy(o)) begin
      errors++;
      $display("FAIL %s_busy op=%0d cycles=%0d required=%0d", name, o, n, exp_busy(o));
    end
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL %s_hilo op=%0d rs=%h rt=%h got hi=%h lo=%h required hi=%h lo=%h",
               name, o, a, b, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || mul_a !== 32'd0 || mul_b !== 32'd0) begin
      errors++;
      $display("FAIL reset busy=%b hi=%h lo=%h mul_a=%h mul_b=%h required all 0", busy, hi, lo, mul_a, mul_b);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_mt();
    run_op("mthi", 3'd4, 32'h1234_5678, 32'd0);
    run_op("mtlo", 3'd5, 32'h9ABC_DEF0, 32'd0);
    run_op("op6", 3'd6, 32'h5555_5555, 32'h6666_6666);
    run_op("op7", 3'd7, 32'h7777_7777, 32'h8888_8888);
  endtask

  task automatic test_mult();
    run_op("mult_neg3x5", 3'd0, 32'hFFFF_FFFD, 32'd5);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL mult_const hi=%h lo=%h required FFFFFFFF FFFFFFF1", hi, lo);
    end
    run_op("mult_negneg", 3'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mult_rand", 3'd0, $urandom, $urandom);
  endtask

  task automatic test_multu();
    int n;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (mul_a !== 32'hFFFF_FFFF || mul_b !== 32'hFFFF_FFFF || busy !== 1'b1) begin
      errors++;
      $display("FAIL multu_operands mul_a=%h mul_b=%h busy=%b required FFFFFFFF FFFFFFFF 1", mul_a, mul_b, busy);
    end
    wait_idle(n);
    checks++;
    if (n !== 1 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_max cycles=%0d hi=%h lo=%h required 1 FFFFFFFE 00000001", n, hi, lo);
    end
    model(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // Operand registers must keep their last value once back in IDLE.
    run_op("mtlo_hold", 3'd5, 32'hABCD_0123, 32'h0000_0007);
    checks++;
    if (mul_a !== 32'hFFFF_FFFF || mul_b !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL mul_hold mul_a=%h mul_b=%h required FFFFFFFF FFFFFFFF", mul_a, mul_b);
    end
  endtask

  task automatic test_div();
    run_op("div_neg7by2", 3'd2, 32'hFFFF_FFF9, 32'd2);
`ifdef HILO_DIV_EN
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_const hi=%h lo=%h required FFFFFFFF FFFFFFFD", hi, lo);
    end
`endif
    run_op("divu_by0", 3'd3, 32'd100, 32'd0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_by0", 3'd2, 32'hFFFF_FF00, 32'd0);
    run_op("divu_rand", 3'd3, $urandom, 32'($urandom_range(1, 1000)));
    run_op("div_rand", 3'd2, $urandom, $urandom);
  endtask

  task automatic test_abort();
    run_op("ab_mthi", 3'd4, 32'h1111_1111, 32'd0);
    run_op("ab_mtlo", 3'd5, 32'h2222_2222, 32'd0);
    // Op alongside abort in IDLE is dropped.
    @(negedge clk);
    op = 3'd4; rs_val = 32'hDEAD_BEEF; op_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; abort = 1'b0;
    checks++;
    if (hi !== 32'h1111_1111 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle hi=%h busy=%b required 11111111 0", hi, busy);
    end
    // Abort during MUL.
    issue(3'd0, 32'h0000_0003, 32'h0000_0007);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
      errors++;
      $display("FAIL abort_mul busy=%b hi=%h lo=%h required 0 11111111 22222222", busy, hi, lo);
    end
`ifdef HILO_DIV_EN
    issue(3'd3, $urandom, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    op = 3'd4; rs_val = 32'hCAFE_F00D; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || hi !== 32'h1111_1111) begin
      errors++;
      $display("FAIL busy_ignore busy=%b hi=%h required 1 11111111", busy, hi);
    end
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
      errors++;
      $display("FAIL abort_div busy=%b hi=%h lo=%h required 0 11111111 22222222", busy, hi, lo);
    end
`endif
    run_op("post_abort", 3'd5, 32'h3333_3333, 32'd0);
  endtask

  task automatic test_reset_mid();
    run_op("rm_mthi", 3'd4, 32'h4444_4444, 32'd0);
`ifdef HILO_DIV_EN
    issue(3'd2, 32'h0000_1000, 32'd7);
    repeat (5) @(posedge clk);
    #1;
`else
    issue(3'd0, 32'h0000_1000, 32'd7);
`endif
    reset_n = 1'b0;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || mul_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid busy=%b hi=%h lo=%h mul_a=%h required 0 0 0 0", busy, hi, lo, mul_a);
    end
    @(negedge clk); reset_n = 1'b1;
    run_op("rm_multu", 3'd1, 32'd3, 32'd4);
    checks++;
    if (lo !== 32'd12 || hi !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_mul hi=%h lo=%h required 0 0000000c", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [2:0] seen;
    int n;
    a = $urandom; b = $urandom;
    @(negedge clk);
    op = 3'd1; rs_val = a; rt_val = b; op_valid = 1'b1;
    @(posedge clk); #1; seen[2] = busy;
    @(posedge clk); #1; seen[1] = busy;
    model(3'd1, a, b);
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL b2b_first hi=%h lo=%h required %h %h", hi, lo, m_hi, m_lo);
    end
    @(posedge clk); #1; seen[0] = busy;
    op_valid = 1'b0;
    checks++;
    if (seen !== 3'b101) begin
      errors++;
      $display("FAIL b2b_busy pattern=%b required 101", seen);
    end
    wait_idle(n);
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL b2b_second hi=%h lo=%h required %h %h", hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_op("rand", 3'($urandom_range(0, 7)), rnd32(), rnd32());
    end
  endtask

  initial begin
    test_reset();
    test_mt();
    test_mult();
    test_multu();
    test_div();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
